// File: rtl/incr_step_unit.sv
// rtl/incr_step_unit.sv - sequenced +1-per-clock increment stage with sticky carry (optional INCR_SATURATE_EN)
module incr_step_unit #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_a,
  input  logic [CNT_W-1:0] in_n,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_s,
  output logic             out_cout,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       acc_q, acc_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             cout_q, cout_d;

  // Incrementer datapath: bit 0 toggles, carry-out only when every bit is set.
  logic [3:0] acc_inc;
  logic       acc_carry;
  assign acc_inc   = acc_q + 4'd1;
  assign acc_carry = &acc_q;

  // State, accumulator, remaining-step counter and sticky carry registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= 4'h0;
      rem_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      cout_q  <= cout_d;
    end
  end

  // Next-state logic: load on accept, one increment per RUN cycle, hold in DONE until taken.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    cout_d  = cout_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          acc_d   = in_a;
          rem_d   = in_n;
          cout_d  = 1'b0;
          state_d = (in_n != '0) ? RUN : DONE;
        end
      end
      RUN: begin
`ifdef INCR_SATURATE_EN
        acc_d = acc_carry ? acc_q : acc_inc;
`else
        acc_d = acc_inc;
`endif
        cout_d = cout_q | acc_carry;
        rem_d  = rem_q - CNT_W'(1);
        if (rem_q == CNT_W'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == RUN);
  assign out_s     = acc_q;
  assign out_cout  = cout_q;

endmodule

// File: tb/tb_incr_step_unit.sv
// tb/tb_incr_step_unit.sv - directed table-driven bench for incr_step_unit
module tb_incr_step_unit;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_a;
  logic [3:0] in_n;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_s;
  logic       out_cout;
  logic       busy;

  int checks;
  int errors;

  incr_step_unit #(.CNT_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_n      (in_n),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_s     (out_s),
    .out_cout  (out_cout),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] a;
    logic [3:0] n;
    logic [3:0] s;
    logic       cout;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  // Waits for in_ready, issues one transaction, measures latency and busy cycles, then takes the result.
  task automatic run_vec(input int idx, input logic [3:0] a, input logic [3:0] n,
                         input logic [3:0] s_req, input logic c_req);
    int wait_cnt;
    int lat;
    int busy_cnt;
    wait_cnt = 0;
    while (!in_ready && wait_cnt < 50) begin
      @(negedge clk);
      wait_cnt++;
    end
    check($sformatf("v%0d_in_ready", idx), in_ready, 1);
    in_valid = 1'b1;
    in_a     = a;
    in_n     = n;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_a     = ~a;
    in_n     = ~n;
    lat      = 0;
    busy_cnt = 0;
    while (!out_valid && lat < 40) begin
      if (busy) busy_cnt++;
      lat++;
      @(negedge clk);
    end
    check($sformatf("v%0d_latency", idx), lat, n);
    check($sformatf("v%0d_busy_cycles", idx), busy_cnt, n);
    check($sformatf("v%0d_out_s", idx), out_s, s_req);
    check($sformatf("v%0d_out_cout", idx), out_cout, c_req);
    check($sformatf("v%0d_done_in_ready", idx), in_ready, 0);
    check($sformatf("v%0d_done_busy", idx), busy, 0);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check($sformatf("v%0d_back_idle", idx), {out_valid, in_ready}, 2'b01);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = 4'h0;
    in_n      = 4'h0;
    out_ready = 1'b0;

    vecs[0] = '{a: 4'hA, n: 4'd1,  s: 4'hB, cout: 1'b0};
    vecs[1] = '{a: 4'h7, n: 4'd0,  s: 4'h7, cout: 1'b0};
    vecs[2] = '{a: 4'h3, n: 4'd4,  s: 4'h7, cout: 1'b0};
`ifdef INCR_SATURATE_EN
    vecs[3] = '{a: 4'hD, n: 4'd5,  s: 4'hF, cout: 1'b1};
    vecs[4] = '{a: 4'h1, n: 4'd15, s: 4'hF, cout: 1'b1};
    vecs[5] = '{a: 4'hF, n: 4'd1,  s: 4'hF, cout: 1'b1};
    vecs[6] = '{a: 4'hE, n: 4'd2,  s: 4'hF, cout: 1'b1};
`else
    vecs[3] = '{a: 4'hD, n: 4'd5,  s: 4'h2, cout: 1'b1};
    vecs[4] = '{a: 4'h1, n: 4'd15, s: 4'h0, cout: 1'b1};
    vecs[5] = '{a: 4'hF, n: 4'd1,  s: 4'h0, cout: 1'b1};
    vecs[6] = '{a: 4'hE, n: 4'd2,  s: 4'h0, cout: 1'b1};
`endif
    vecs[7] = '{a: 4'h0, n: 4'd3,  s: 4'h3, cout: 1'b0};

    #12;
    check("reset_outputs", {out_s, out_cout, out_valid, busy, in_ready}, 8'b0000_0001);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      run_vec(i, vecs[i].a, vecs[i].n, vecs[i].s, vecs[i].cout);
    end

    // Backpressure: result held for 4 cycles while upstream keeps pushing.
    in_valid = 1'b1;
    in_a     = 4'h0;
    in_n     = 4'd3;
    @(posedge clk);
    @(negedge clk);
    in_a = 4'h5;
    in_n = 4'd1;
    for (int k = 0; k < 3; k++) @(negedge clk);
    check("bp_out_valid", out_valid, 1);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("bp_hold%0d", k), {out_s, out_cout, in_ready, out_valid}, 7'b0011_001);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_idle", {in_ready, out_valid, busy}, 3'b100);

    // Reset in the middle of a long run discards the in-flight result.
    in_valid = 1'b1;
    in_a     = 4'h0;
    in_n     = 4'd10;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("mid_run_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("mid_run_reset", {out_s, out_cout, out_valid, busy, in_ready}, 8'b0000_0001);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
`ifdef INCR_SATURATE_EN
    run_vec(8, 4'hF, 4'd1, 4'hF, 1'b1);
`else
    run_vec(8, 4'hF, 4'd1, 4'h0, 1'b1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
